// File: rtl/l2_req_arbiter.sv
// N-channel L1-to-L2 line-port arbiter: round-robin grant, one transaction in flight.
// Define L2_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module l2_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_read,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_address,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_wdata,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic [NUM_REQ-1:0]               req_resp,
  output logic                             l2_read,
  output logic                             l2_write,
  output logic [ADDR_WIDTH-1:0]            l2_address,
  output logic [LINE_WIDTH-1:0]            l2_wdata,
  input  logic [LINE_WIDTH-1:0]            l2_rdata,
  input  logic                             l2_resp
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       grant_q, grant_d;
  logic                   l2_read_q, l2_read_d;
  logic                   l2_write_q, l2_write_d;
  logic [ADDR_WIDTH-1:0]  l2_address_q, l2_address_d;
  logic [LINE_WIDTH-1:0]  l2_wdata_q, l2_wdata_d;

  logic [NUM_REQ-1:0]     active;
  logic                   found;
  logic [PTR_W-1:0]       win;
  int                     idx;

  assign active = req_read | req_write;

  // Winner search: first active channel scanning upward from the start index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef L2_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
`endif
      if (!found && active[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

`ifdef L2_ARB_FIXED_PRIO_EN
  logic rr_ptr_unused;
  assign rr_ptr_unused = ^rr_ptr_q;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = win;
          // Both strobes on one channel is treated as a write.
          l2_write_d   = req_write[win];
          l2_read_d    = ~req_write[win];
          l2_address_d = req_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          l2_wdata_d   = req_wdata[int'(win)*LINE_WIDTH +: LINE_WIDTH];
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (l2_resp) begin
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
          state_d    = DONE;
`ifdef L2_ARB_FIXED_PRIO_EN
          rr_ptr_d   = '0;
`else
          rr_ptr_d   = (grant_q == PTR_W'(NUM_REQ-1)) ? '0 : grant_q + PTR_W'(1);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
    end
  end

  // Completion strobe and read line pass straight through to the granted channel.
  always_comb begin
    req_resp = '0;
    if (state_q == BUSY) req_resp[grant_q] = l2_resp;
  end

  assign req_rdata  = l2_rdata;
  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;

endmodule
